// File: rtl/divider_array_sched_if.sv
// Request and response handshakes around the shared 16/8 array divider.
// Two requesters feed the scheduler; one consumer drains responses.
interface divider_array_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_n;
  logic [7:0]  req0_d;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_n;
  logic [7:0]  req1_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_q;
  logic [7:0]  rsp_r;
  logic [1:0]  rsp_err;

  modport master (
    output req0_valid, req0_n, req0_d,
    output req1_valid, req1_n, req1_d,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err
  );

  modport slave (
    input  req0_valid, req0_n, req0_d,
    input  req1_valid, req1_n, req1_d,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err
  );
endinterface

// File: rtl/divider_array_sched.sv
// Round-robin sequencer for the shared 16/8 array divider.
// Screens div-by-zero/overflow, then holds operands SETTLE cycles.
module divider_array_sched #(
  parameter int unsigned SETTLE = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  divider_array_sched_if.slave        bus,
  output logic [15:0]                 div_n,
  output logic [7:0]                  div_d,
  input  logic [7:0]                  div_q,
  input  logic [7:0]                  div_r,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t      state;
  state_t      state_nx;
  logic        last_grant;
  logic [3:0]  cnt;
  logic        grant0;
  logic        grant1;
  logic        acc0;
  logic        acc1;
  logic        acc;
  logic [15:0] sel_n;
  logic [7:0]  sel_d;
  logic        dz;
  logic        ovf;
  logic        rsp_id_q;
  logic [7:0]  rsp_q_q;
  logic [7:0]  rsp_r_q;
  logic [1:0]  rsp_err_q;

  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);

  assign bus.req0_ready = rst_n & (state == IDLE) & grant0;
  assign bus.req1_ready = rst_n & (state == IDLE) & grant1;

  assign acc0 = bus.req0_valid & bus.req0_ready;
  assign acc1 = bus.req1_valid & bus.req1_ready;
  assign acc  = acc0 | acc1;

  assign sel_n = acc1 ? bus.req1_n : bus.req0_n;
  assign sel_d = acc1 ? bus.req1_d : bus.req0_d;

  // Quotient exceeds 8 bits exactly when the high byte reaches d.
  assign dz  = (sel_d == 8'h00);
  assign ovf = ~dz & (sel_n[15:8] >= sel_d);

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_q     = rsp_q_q;
  assign bus.rsp_r     = rsp_r_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (acc) state_nx = (dz | ovf) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_nx = RESP;
      RESP: if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      div_n      <= 16'h0000;
      div_d      <= 8'h00;
      rsp_id_q   <= 1'b0;
      rsp_q_q    <= 8'h00;
      rsp_r_q    <= 8'h00;
      rsp_err_q  <= 2'b00;
    end else if (acc) begin
      last_grant <= acc1;
      rsp_id_q   <= acc1;
      unique case (1'b1)
        dz: begin
          rsp_err_q <= 2'b01;
          rsp_q_q   <= 8'hFF;
          rsp_r_q   <= sel_n[7:0];
        end
        ovf: begin
          rsp_err_q <= 2'b10;
          rsp_q_q   <= 8'hFF;
          rsp_r_q   <= 8'hFF;
        end
        default: begin
          div_n <= sel_n;
          div_d <= sel_d;
          cnt   <= CNT_INIT;
        end
      endcase
    end else if (state == WAIT) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        rsp_q_q   <= div_q;
        rsp_r_q   <= div_r;
        rsp_err_q <= 2'b00;
      end
    end
  end

endmodule

// File: doc/divider_array_sched.md
# divider_array_sched

Sequencing and sharing controller for the 16/8 array divider (exact or approximate variant, instantiated outside this block). It accepts divide requests from two independent requesters, arbitrates round-robin, and drives registered operands into the shared combinational array. It holds those operands stable for a programmable number of settle cycles, then captures quotient and remainder. Divide-by-zero and quotient-overflow cases are screened before the array is used and are reported with an error code.

## Interface
- SETTLE, 2: cycles operands are held before the array outputs are sampled; legal range 1..15 (multicycle budget for the array's borrow chain).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_n  in  16  requester 0 dividend.
- req0_d  in  8  requester 0 divisor.
- req1_valid / req1_ready / req1_n / req1_d: same as requester 0, for requester 1.
- div_n  out  16  registered dividend to the array.
- div_d  out  8  registered divisor to the array.
- div_q  in  8  array quotient.
- div_r  in  8  array remainder.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the request.
- rsp_q  out  8  quotient.
- rsp_r  out  8  remainder.
- rsp_err  out  2  error code: 00 ok, 01 divide-by-zero, 10 overflow.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- Grant (IDLE only):
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - last_grant resets to 1, so requester 0 wins the first contest.
- reqX_ready = (state==IDLE) & grant_X. It may depend on reqX_valid. A requester's valid must not depend on its ready.
- On accept (valid & ready at an edge):
  - Latch n, d and id.
  - Update last_grant.
  - Screen the operands (see below).
- Screening, evaluated on the accepted operands:
  - d==0: go to RESP with err=01, q=FF, r=n[7:0]. div_n/div_d are not updated.
  - else n[15:8] >= d: go to RESP with err=10, q=FF, r=FF. div_n/div_d are not updated.
  - else: load div_n=n and div_d=d, set cnt=SETTLE-1, go to WAIT.
- WAIT:
  - At each edge with cnt!=0, decrement cnt.
  - At the edge with cnt==0, capture div_q into rsp_q and div_r into rsp_r, set err=00, go to RESP.
- RESP:
  - rsp_valid=1. All rsp_* outputs are held stable.
  - At an edge with rsp_ready=1, go to IDLE and drop rsp_valid.
  - No requests are accepted in RESP.
- div_n/div_d keep their last value outside WAIT.
- Arithmetic correctness is that of the attached array; this block does not alter q/r values.

## Timing
- Reset values, applied immediately and asynchronously:
  - state=IDLE, last_grant=1, cnt=0.
  - div_n=0, div_d=0.
  - rsp_valid=0, rsp_id=0, rsp_q=0, rsp_r=0, rsp_err=0, busy=0.
  - req0_ready=req1_ready=0 while rst_n=0.
- Normal latency, accept edge E0:
  - div_n/div_d are valid after E0.
  - div_q/div_r are sampled at edge E0+SETTLE.
  - rsp_valid is high from after E0+SETTLE.
- Error latency: rsp_valid is high from after E0 itself (one cycle).
- Throughput:
  - The earliest next accept is the cycle after the rsp_ready handshake edge (no bypass).
  - Max rate: one op per SETTLE+2 cycles.
- rsp_ready low: response held indefinitely, no accepts, both req ready signals low.
- Reset mid-WAIT or mid-RESP: the operation is discarded and no response is produced. The first accept after release follows the reset arbitration order.
- Simultaneous valid on both requesters every cycle: strict alternation 0,1,0,1...

## Test plan
- Exact array attached, SETTLE=2: req0 n=1000, d=7 accepted at E0 -> rsp_valid after E2, q=142, r=6, err=00, id=0.
- req1 n=16'h0800, d=8'h08 -> rsp_valid the cycle after accept, err=10, q=FF, r=FF, id=1, div_n/div_d unchanged.
- req0 n=16'h1234, d=0 -> err=01, q=FF, r=8'h34, no WAIT state entered.
- Both requesters valid continuously with distinct operands, rsp_ready=1 -> rsp_id sequence 0,1,0,1; each ready pulse lasts one cycle; 4 ops complete in 4×(SETTLE+2) cycles.
- rsp_ready held low 5 cycles after rsp_valid -> rsp_* stable, req0_ready/req1_ready stay 0; response consumed on the first rsp_ready cycle.
- rst_n pulsed low during WAIT -> all outputs reach reset values asynchronously, no response emitted; after release, with both valid, requester 0 is granted first.
